// File: rtl/enter_capture_unit_if.sv
// rtl/enter_capture_unit_if.sv - enter/inputdata capture handshake bundle
// master: the capture unit; slave: the control unit / environment side.
interface enter_capture_unit_if #(
  parameter int DATA_W = 8
);
  logic              enter;
  logic [DATA_W-1:0] inputdata;
  logic              loaddata;
  logic              inputdata_ready;
  logic [DATA_W-1:0] capdata;
  logic              overrun;

  modport master (
    input  enter, inputdata, loaddata,
    output inputdata_ready, capdata, overrun
  );

  modport slave (
    output enter, inputdata, loaddata,
    input  inputdata_ready, capdata, overrun
  );
endinterface

// File: rtl/enter_capture_unit.sv
// rtl/enter_capture_unit.sv - debounced enter button capturing one data byte per press
// Optional ENTER_AUTO_REPEAT_EN: a held button re-captures every REPEAT_CYCLES cycles.
module enter_capture_unit #(
  parameter int DATA_W          = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  enter_capture_unit_if.master  bus
);
  localparam int CNT_MAX = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES);
`ifdef ENTER_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sync1_q, sync2_q;
  logic              enter_s;
  logic              capture;
  logic              ready_q, ready_d;
  logic              overrun_q, overrun_d;
  logic [DATA_W-1:0] capdata_q, capdata_d;

  assign enter_s = sync2_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (enter_s) begin
          state_d = PRESS_DB;
          cnt_d   = CNT_W'(1);
        end
      end
      PRESS_DB: begin
        if (!enter_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          capture = 1'b1;
          state_d = HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!enter_s) begin
          state_d = RELEASE_DB;
          cnt_d   = CNT_W'(1);
        end
`ifdef ENTER_AUTO_REPEAT_EN
        else if (cnt_q == REP_LAST) begin
          capture = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      RELEASE_DB: begin
        // A high sample during release is bounce: return to HELD without a new capture.
        if (enter_s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A capture coinciding with loaddata consumes the old byte, so it is not an overrun.
  always_comb begin
    capdata_d = capture ? bus.inputdata : capdata_q;
    overrun_d = overrun_q | (capture & ready_q & ~bus.loaddata);
    if (capture) begin
      ready_d = 1'b1;
    end else if (bus.loaddata) begin
      ready_d = 1'b0;
    end else begin
      ready_d = ready_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
      capdata_q <= '0;
    end else begin
      sync1_q   <= bus.enter;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      overrun_q <= overrun_d;
      capdata_q <= capdata_d;
    end
  end

  assign bus.inputdata_ready = ready_q;
  assign bus.capdata         = capdata_q;
  assign bus.overrun         = overrun_q;
endmodule

// File: tb/tb_enter_capture_unit.sv
// tb/tb_enter_capture_unit.sv - randomized scoreboard bench for enter_capture_unit
// Reference model works on run lengths of the synchronized button level.
module tb_enter_capture_unit;
  localparam int D = 4;
  localparam int R = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  enter_capture_unit_if #(.DATA_W(8)) bus ();

  enter_capture_unit #(
    .DATA_W(8),
    .DEBOUNCE_CYCLES(D),
    .REPEAT_CYCLES(R)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct packed {
    logic       rdy;
    logic [7:0] cap;
    logic       ovr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  // model state
  bit       dly[2];
  int       run_hi = 0;
  int       run_lo = 0;
  int       hold = 0;
  bit       armed = 1'b1;
  bit       m_rdy = 1'b0;
  bit       m_ovr = 1'b0;
  bit [7:0] m_cap = 8'h00;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_step(input bit r, input bit e, input bit [7:0] d, input bit l);
    bit es;
    bit cap_ev;
    if (r) begin
      dly[0] = 1'b0; dly[1] = 1'b0;
      run_hi = 0; run_lo = 0; hold = 0; armed = 1'b1;
      m_rdy = 1'b0; m_ovr = 1'b0; m_cap = 8'h00;
    end else begin
      es     = dly[1];
      dly[1] = dly[0];
      dly[0] = e;
      cap_ev = 1'b0;
      if (es) begin
        run_lo = 0;
        run_hi++;
        if (armed && run_hi == D + 1) begin
          cap_ev = 1'b1;
          armed  = 1'b0;
          hold   = 0;
        end
`ifdef ENTER_AUTO_REPEAT_EN
        else if (!armed) begin
          if (run_hi == 1) hold = 0;
          else begin
            hold++;
            if (hold == R) begin
              cap_ev = 1'b1;
              hold   = 0;
            end
          end
        end
`endif
      end else begin
        run_hi = 0;
        if (!armed) begin
          run_lo++;
          if (run_lo == D + 1) begin
            armed  = 1'b1;
            run_lo = 0;
          end
        end
      end
      if (cap_ev) begin
        if (m_rdy && !l) m_ovr = 1'b1;
        m_rdy = 1'b1;
        m_cap = d;
      end else if (l) begin
        m_rdy = 1'b0;
      end
    end
    exp_q.push_back({m_rdy, m_cap, m_ovr});
  endtask

  task automatic cycle(input bit r, input bit e, input bit [7:0] d, input bit l);
    @(negedge clk);
    reset         = r;
    bus.enter     = e;
    bus.inputdata = d;
    bus.loaddata  = l;
    model_step(r, e, d, l);
  endtask

  task automatic seg(input bit e, input int len, input bit [7:0] d);
    for (int i = 0; i < len; i++) cycle(1'b0, e, d, 1'b0);
  endtask

  initial begin
    bus.enter     = 1'b0;
    bus.inputdata = 8'h00;
    bus.loaddata  = 1'b0;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t x;
        x = exp_q.pop_front();
        chk("inputdata_ready", 8'(bus.inputdata_ready), 8'(x.rdy));
        chk("capdata", bus.capdata, x.cap);
        chk("overrun", 8'(bus.overrun), 8'(x.ovr));
      end
    end
  end

  initial begin
    bit       lvl;
    int       len;
    bit [7:0] dat;

    // reset with enter held, then release with enter still high
    cycle(1'b1, 1'b1, 8'hFF, 1'b0);
    cycle(1'b1, 1'b1, 8'hFF, 1'b0);
    seg(1'b1, 12, 8'hFF);
    cycle(1'b0, 1'b0, 8'hFF, 1'b1);
    seg(1'b0, 10, 8'hFF);

    // clean press, consume, release
    seg(1'b1, 20, 8'hA5);
    cycle(1'b0, 1'b1, 8'hA5, 1'b1);
    seg(1'b0, 10, 8'hA5);

    // glitch, then release bounce
    seg(1'b1, 3, 8'h5A);
    seg(1'b0, 10, 8'h5A);
    seg(1'b1, 10, 8'h66);
    seg(1'b0, 1, 8'h66);
    seg(1'b1, 1, 8'h66);
    seg(1'b0, 1, 8'h66);
    seg(1'b1, 2, 8'h66);
    seg(1'b0, 10, 8'h66);
    cycle(1'b0, 1'b0, 8'h66, 1'b1);

    // overrun, then loaddata must not clear it
    seg(1'b1, 8, 8'h11);
    seg(1'b0, 10, 8'h11);
    seg(1'b1, 8, 8'h22);
    seg(1'b0, 10, 8'h22);
    cycle(1'b0, 1'b0, 8'h22, 1'b1);
    seg(1'b0, 3, 8'h22);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);

    // simultaneous capture and consume
    seg(1'b1, 10, 8'h33);
    seg(1'b0, 10, 8'h33);
    for (int j = 0; j < 12; j++) cycle(1'b0, 1'b1, 8'h44, j == 6);
    seg(1'b0, 10, 8'h44);

    // reset mid press debounce
    seg(1'b1, 4, 8'h77);
    cycle(1'b1, 1'b1, 8'h77, 1'b0);
    seg(1'b0, 10, 8'h77);

    // long hold (auto-repeat when enabled, single capture otherwise)
    seg(1'b1, 40, 8'h99);
    seg(1'b0, 10, 8'h99);

    // randomized segments
    lvl = 1'b0;
    for (int i = 0; i < 200; i++) begin
      lvl = ~lvl;
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, D + 1) : $urandom_range(D + 2, 14);
      dat = 8'($urandom);
      for (int k = 0; k < len; k++)
        cycle($urandom_range(0, 79) == 0, lvl, dat, $urandom_range(0, 5) == 0);
    end
    seg(1'b0, 4, 8'h00);

    @(posedge clk);
    #2;
    chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
